// File: rtl/hdmi_pixel_packer.sv
// hdmi_pixel_packer: packs PPW pixels into DATA_W words with frame-start/line-end markers; HDMI_PACK_LINE_CNT_EN puts the line index in line-end markers.
// Latency: pixel on inputs at N -> word in FIFO at N+2 -> hdmi_axi_tx_valid at N+3.
// Backpressure: ready/valid through an output FIFO; a write into a full FIFO is dropped and the rest of the frame is discarded.

module hdmi_pixel_packer_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         full,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          rd_fire;

    assign rd_fire = rd_vld & rd_rdy;
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

    // A freshly written word becomes visible one cycle after it lands; words already held stay visible back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (wr_vld)  wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + (AW+1)'(wr_vld) - (AW+1)'(rd_fire);
            rd_vld <= (count - (AW+1)'(rd_fire)) != '0;
        end
    end
endmodule

module hdmi_pixel_packer #(
    parameter int         DATA_W     = 64,
    parameter int         PIX_W      = 24,
    parameter logic [7:0] NODE_INFO  = 8'h12,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic              video_clk_in,
    input  logic              rst,
    input  logic              init_over,
    input  logic              video_vs_in,
    input  logic              video_de_in,
    input  logic [PIX_W-1:0]  video_rgb_in,
    input  logic              hdmi_axi_tx_ready,
    output logic              hdmi_axi_tx_valid,
    output logic [DATA_W-1:0] hdmi_axi_tx_data,
    output logic              frame_overflow,
    output logic [15:0]       frame_cnt
);
    localparam int PPW   = (DATA_W - 16) / PIX_W;
    localparam int PAY_W = DATA_W - 16;

    if (PPW < 1 || PPW > 63) begin : g_ppw_chk
        $error("hdmi_pixel_packer: pixels per word must be 1..63");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("hdmi_pixel_packer: FIFO_DEPTH must be a power of two >= 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EOL, S_DROP} state_t;

    logic              vs_d0, vs_d1, de_d0, de_d1, vs_fall, de_fall;
    logic [PIX_W-1:0]  rgb_d0;
    state_t            state;
    logic [5:0]        slot;
    logic              last_slot;
    logic [PAY_W-1:0]  pix_buf, buf_ins;
    logic [DATA_W-1:0] eol_now, eol_late, wr_dat;
    logic              wr_en, wr_ok, fifo_full, rd_fire;
`ifdef HDMI_PACK_LINE_CNT_EN
    logic [15:0]       line_cnt;
`endif

    function automatic logic [DATA_W-1:0] marker(input logic [5:0] sub, input logic [7:0] fill);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 16; i < DATA_W; i++) w[i] = fill[i % 8];
        w[15:0] = {2'd3, sub, NODE_INFO};
        return w;
    endfunction

    always_ff @(posedge video_clk_in) begin
        if (rst) begin
            vs_d0  <= 1'b0;
            vs_d1  <= 1'b0;
            de_d0  <= 1'b0;
            de_d1  <= 1'b0;
            rgb_d0 <= '0;
        end else begin
            vs_d0  <= init_over & video_vs_in;
            de_d0  <= init_over & video_de_in;
            rgb_d0 <= init_over ? video_rgb_in : '0;
            vs_d1  <= vs_d0;
            de_d1  <= de_d0;
        end
    end

    assign vs_fall   = vs_d1 & ~vs_d0;
    assign de_fall   = ~de_d0 & de_d1;
    assign last_slot = (slot == 6'(PPW - 1));
    assign rd_fire   = hdmi_axi_tx_valid & hdmi_axi_tx_ready;
    assign wr_ok     = ~fifo_full | rd_fire;

    always_comb begin
        buf_ins = pix_buf;
        for (int k = 0; k < PPW; k++) begin
            if (slot == 6'(k)) buf_ins[k*PIX_W +: PIX_W] = rgb_d0;
        end
    end

    // The deferred marker belongs to the line whose end already bumped the counter.
    always_comb begin
        eol_now  = marker(6'd1, 8'hF0);
        eol_late = eol_now;
`ifdef HDMI_PACK_LINE_CNT_EN
        eol_now[31:16]  = line_cnt;
        eol_late[31:16] = line_cnt - 16'd1;
`endif
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_dat = '0;
        if (vs_fall) begin
            wr_en  = 1'b1;
            wr_dat = marker(6'd2, 8'hFE);
        end else if (state == S_RUN) begin
            if (de_d0 && last_slot) begin
                wr_en  = 1'b1;
                wr_dat = {buf_ins, 2'd2, 6'(PPW), NODE_INFO};
            end else if (de_fall) begin
                wr_en  = 1'b1;
                wr_dat = (slot != '0) ? {pix_buf, 2'd2, slot, NODE_INFO} : eol_now;
            end
        end else if (state == S_EOL) begin
            wr_en  = 1'b1;
            wr_dat = eol_late;
        end
    end

    always_ff @(posedge video_clk_in) begin
        if (rst) begin
            state          <= S_IDLE;
            slot           <= '0;
            pix_buf        <= '0;
            frame_cnt      <= '0;
            frame_overflow <= 1'b0;
`ifdef HDMI_PACK_LINE_CNT_EN
            line_cnt       <= '0;
`endif
        end else begin
            if (wr_en && !wr_ok) frame_overflow <= 1'b1;
            if (vs_fall) begin
                slot    <= '0;
                pix_buf <= '0;
`ifdef HDMI_PACK_LINE_CNT_EN
                line_cnt <= '0;
`endif
                if (wr_ok) begin
                    state     <= S_RUN;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_RUN: begin
                        if (de_d0) begin
                            if (!last_slot) begin
                                slot    <= slot + 6'd1;
                                pix_buf <= buf_ins;
                            end else if (wr_ok) begin
                                slot    <= '0;
                                pix_buf <= '0;
                            end else begin
                                state <= S_DROP;
                            end
                        end else if (de_fall) begin
`ifdef HDMI_PACK_LINE_CNT_EN
                            line_cnt <= line_cnt + 16'd1;
`endif
                            if (!wr_ok) begin
                                state <= S_DROP;
                            end else if (slot != '0) begin
                                state   <= S_EOL;
                                slot    <= '0;
                                pix_buf <= '0;
                            end
                        end
                    end
                    S_EOL: begin
                        if (!wr_ok) begin
                            state <= S_DROP;
                        end else begin
                            state <= S_RUN;
                            if (de_d0) begin
                                slot    <= slot + 6'd1;
                                pix_buf <= buf_ins;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    hdmi_pixel_packer_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (video_clk_in),
        .rst    (rst),
        .wr_vld (wr_en & wr_ok),
        .wr_dat (wr_dat),
        .rd_rdy (hdmi_axi_tx_ready),
        .full   (fifo_full),
        .rd_vld (hdmi_axi_tx_valid),
        .rd_dat (hdmi_axi_tx_data)
    );
endmodule

// File: doc/hdmi_pixel_packer.md
Name: hdmi_pixel_packer

Overview:
- Parametrised successor to the HDMI-to-AXI word packer. Packs PPW pixels of PIX_W bits into DATA_W-bit words with a 16-bit header, and inserts frame-start and line-end marker words.
- Adds a ready/valid output with an internal FIFO, overflow detection with frame resync, a frame counter, and a parametrised node ID.
- Sits between the HDMI receiver (video clock domain) and the SFP/AXI transmit path.

Parameters:
- DATA_W, 64: output word width; payload is bits [DATA_W-1:16].
- PIX_W, 24: pixel width. PPW = (DATA_W-16)/PIX_W; elaboration error unless 1 <= PPW <= 63.
- NODE_INFO, 8'h12: node ID placed in header bits [7:0].
- FIFO_DEPTH, 16: output FIFO entries; power of two, >= 4.

Ports:
- video_clk_in  in  1  pixel clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- init_over  in  1  HDMI chip init done. While low, vs/de/rgb are treated as 0.
- video_vs_in  in  1  vertical sync.
- video_de_in  in  1  data enable.
- video_rgb_in  in  PIX_W  pixel data.
- hdmi_axi_tx_ready  in  1  downstream ready.
- hdmi_axi_tx_valid  out  1  output word valid.
- hdmi_axi_tx_data  out  DATA_W  output word.
- frame_overflow  out  1  sticky; FIFO full dropped a word.
- frame_cnt  out  16  count of frame-start markers written, wraps.

Behaviour:
- Reset (synchronous, rst=1) clears:
  - all outputs to 0;
  - FIFO empty, packer state IDLE, slot counter 0, line counter 0.
- Input stage: vs, de and rgb are registered once (d0); vs is registered again (d1). VS falling edge = d1 & ~d0. DE falling edge = ~de_d0 & de_d1.
- Header fields:
  - [15:14] kind: 2'd2 = pixel word, 2'd3 = marker.
  - [13:8] for pixel words: valid pixel count 1..PPW; for markers: subtype, 6'd1 = line end, 6'd2 = frame start.
  - [7:0] NODE_INFO.
- Pixel slot k (k = 0 first pixel) occupies bits [16+(k+1)*PIX_W-1 : 16+k*PIX_W]. Unused slots and any leftover bits are 0.
- Frame-start marker payload: all 8'hFE bytes.
- Line-end marker payload: all 8'hF0 bytes (see LINE_CNT_EN).
- Packer FSM:
  - IDLE: pixels are ignored. VS falling edge writes the frame-start marker and moves to RUN.
  - RUN:
    - Each de_d0 cycle stores a pixel in the next slot. When the slot count reaches PPW, write a pixel word with count PPW and reset the slot count to 0.
    - On DE falling edge: if slot count > 0, write a partial word (count = slot count), then the line-end marker on the next cycle (state EOL). Otherwise write the line-end marker in the same cycle. Increment the line counter.
  - EOL: writes the pending line-end marker, then returns to RUN. A de_d0 pixel arriving in EOL is stored normally; EOL never stalls the input.
  - DROP: entered on overflow. Pixels and DE edges are ignored until the next VS falling edge.
- Priority: a VS falling edge in any state discards the partial word and any pending marker, resets the slot and line counters, writes the frame-start marker, increments frame_cnt, and goes to RUN.
- At most one FIFO write per cycle.
- Overflow: if a write is due while the FIFO is full, the word is dropped, frame_overflow is set (it clears only on rst), and the FSM goes to DROP.
  - A frame start dropped on a full FIFO leaves the FSM in IDLE and does not count in frame_cnt.
- Output:
  - First-word fall-through. hdmi_axi_tx_valid rises the cycle after the first write into an empty FIFO.
  - The word is held stable until tx_valid & tx_ready. A simultaneous read and write while full is allowed.
- Latency: the pixel completing a word is on the inputs at cycle N; the word reaches the FIFO at N+2 and hdmi_axi_tx_valid at N+3 (FIFO empty, ready high).

Optional Feature:
- HDMI_PACK_LINE_CNT_EN defined: line-end marker payload bits [31:16] carry the 16-bit line index (first line = 0, reset at frame start); the upper payload bits stay 8'hF0 fill.
- Undefined: the whole payload is 8'hF0 fill and the line counter is not implemented.

Test Plan:
- Reset, then VS falling edge, ready=1 -> one word 64'hFEFEFEFEFEFE_C212; frame_cnt=1.
- Frame start, then DE high for 4 pixels 0x111111, 0x222222, 0x333333, 0x444444 -> 64'h222222111111_8212, then 64'h444444333333_8212, then 64'hF0F0F0F0F0F0_C112 (line index 0 in [31:16] if the feature is enabled). First pixel word appears 3 cycles after pixel 2 is applied.
- 3-pixel line 0xAAAAAA, 0xBBBBBB, 0xCCCCCC -> 64'hBBBBBBAAAAAA_8212, then 64'h000000CCCCCC_8112, then the line-end marker on the next cycle.
- ready=0 with FIFO_DEPTH=4 and a 12-pixel line -> frame_overflow=1 after the 5th write attempt; further pixels are dropped. Next VS falling edge with ready=1 -> frame-start marker and normal packing resume; frame_overflow stays 1.
- VS falling edge while one pixel is pending in a word -> the partial word is discarded, the frame-start marker is emitted, and no line-end marker is emitted.
- PIX_W=16, DATA_W=64 (PPW=3) -> after 3 pixels, word count field is 3 and payload {p2,p1,p0}.
